flags_unit: RTL
===============

# flags_unit

Producer side of the NZCV condition flags consumed by the branch condition checker. The block sits in the execute stage beside the ALU. It derives N, Z, C and V from each flag-setting ALU operation and holds them in an architectural flag register. It also keeps a one-deep shadow copy, so a speculative flag update can be committed or rolled back on a pipeline flush. Its `Flags` output uses the exact bit packing the condition checker expects.

## Interface
- `WIDTH`, 32, datapath width of ALU operands and result
- `clk` in 1: core clock, rising-edge
- `rst` in 1: asynchronous, active-high reset
- `ALUControl` in 3: `3'b000` ADD, `3'b001` SUB, `3'b010` AND, `3'b011` OR, `3'b100` XOR, others = non-arithmetic
- `SrcA` in WIDTH: ALU operand A
- `SrcB` in WIDTH: ALU operand B
- `ALUResult` in WIDTH: ALU result for the same operation
- `FlagWrite` in 1: the current execute-stage instruction updates the flags
- `Stall` in 1: execute stage held; suppresses `FlagWrite`
- `Commit` in 1: the oldest uncommitted flag update becomes architectural
- `Flush` in 1: discard the uncommitted update and restore the shadow
- `Flags` out 4: {V,C,Z,N}; `Flags[0]`=N, `[1]`=Z, `[2]`=C, `[3]`=V
- `FlagsPending` out 1: an uncommitted flag update is held

## Operation
- Effective write: `we = FlagWrite & ~Stall`.
- N = `ALUResult[WIDTH-1]`.
- Z = (`ALUResult == 0`).
- ADD:
  - C = bit WIDTH of the internal (WIDTH+1)-bit `SrcA + SrcB`.
  - V = (A[msb]==B[msb]) & (R[msb]!=A[msb]).
- SUB:
  - C = no-borrow, i.e. (`SrcA >= SrcB`) unsigned.
  - V = (A[msb]!=B[msb]) & (R[msb]!=A[msb]).
- AND/OR/XOR and undefined codes: C=0, V=0; N and Z computed normally.
- Registers: `flags_q[3:0]`, `shadow_q[3:0]`, state ∈ {CLEAN, PENDING}.
- CLEAN:
  - `we` → `shadow_q<=flags_q`, `flags_q<=new`, go to PENDING.
  - `Commit`/`Flush` without `we` are ignored.
- PENDING, `Flush` (highest priority):
  - `flags_q<=shadow_q`, go to CLEAN.
  - A same-cycle `we` and `Commit` are dropped.
- PENDING, `Commit` & `we`:
  - `shadow_q<=flags_q`, `flags_q<=new`, stay in PENDING.
- PENDING, `Commit` only: go to CLEAN; flags unchanged.
- PENDING, `we` only:
  - `flags_q<=new`, stay in PENDING.
  - `shadow_q` is kept, since it still holds the last committed value.
- `FlagsPending` = (state==PENDING).
- Reset values: `Flags`=4'b0000, `FlagsPending`=0, `shadow_q`=0, state=CLEAN.

## Timing
- Default: new flags appear on `Flags` one cycle after the `we` edge. This means one cycle of latency from write to the condition checker.
- `Flush` restore is visible the cycle after the flush edge.
- `FlagsPending` follows the same edge as the state register.
- Reset asserted mid-operation clears all state immediately and asynchronously. Any pending update is lost.
- No combinational path from `Commit` or `Flush` to `Flags`.

## Configuration
- `FLAGS_BYPASS_EN` defined:
  - When `we` is high and `Flush` is low, `Flags` combinationally shows the newly computed flags in the same cycle. Otherwise it shows `flags_q`.
  - Lets a branch immediately behind a flag-setter resolve without a bubble.
  - The register update, shadow and FSM are identical.
- Undefined: `Flags` = `flags_q` only, with no combinational path from `SrcA`, `SrcB` or `ALUResult`.

## Test plan
- Reset, then hold `rst`=1 mid-stream:
  - `Flags`=0000 and `FlagsPending`=0 asynchronously, before the next clock edge.
- ADD, A=0x7FFFFFFF, B=1, R=0x80000000, `FlagWrite`=1:
  - Next cycle `Flags`=4'b1001 (V=1, N=1).
  - `FlagsPending`=1.
- SUB, A=5, B=5, R=0, then `Commit`:
  - `Flags`=4'b0110 (C=1, Z=1).
  - `FlagsPending` drops after the commit edge.
- Commit flags 0110, then SUB A=3, B=5, R=0xFFFFFFFE, then `Flush`:
  - `Flags`=0001 for one cycle, then restored to 0110.
  - `FlagsPending`=0.
- Commit and a new ADD write in the same cycle, then `Flush`:
  - Flags roll back to the value committed in that cycle, not to the older value.
- `Stall`=1 with `FlagWrite`=1:
  - `Flags` and the state are unchanged.
- With `FLAGS_BYPASS_EN`, an AND with R=0:
  - `Flags[1]`=1 in the same cycle as `we`.

Source files
------------

// File: rtl/flags_unit_if.sv
// ALU-side bundle for flags_unit: operands, result, flag-write/stall and
// commit/flush controls in, packed NZCV flags and pending indication out.
interface flags_unit_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [WIDTH-1:0] ALUResult;
    logic             FlagWrite;
    logic             Stall;
    logic             Commit;
    logic             Flush;
    logic [3:0]       Flags;
    logic             FlagsPending;

    modport master (
        output ALUControl, SrcA, SrcB, ALUResult, FlagWrite, Stall, Commit, Flush,
        input  Flags, FlagsPending
    );

    modport slave (
        input  ALUControl, SrcA, SrcB, ALUResult, FlagWrite, Stall, Commit, Flush,
        output Flags, FlagsPending
    );
endinterface

// File: rtl/flags_unit.sv
// NZCV flag producer with a one-deep shadow for speculative commit/rollback.
// Define FLAGS_BYPASS_EN to forward freshly computed flags onto Flags in the write cycle.
//
// state   | meaning
// CLEAN   | flags_q is architectural, nothing to roll back
// PENDING | flags_q holds an uncommitted update, shadow_q the last committed value
module flags_unit #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst,
    flags_unit_if.slave bus
);
    typedef enum logic {CLEAN, PENDING} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] new_flags;
    logic       we;
    logic       n_flag, z_flag, c_flag, v_flag;
    logic       a_msb, b_msb, r_msb;

    assign we    = bus.FlagWrite & ~bus.Stall;
    assign a_msb = bus.SrcA[WIDTH-1];
    assign b_msb = bus.SrcB[WIDTH-1];
    assign r_msb = bus.ALUResult[WIDTH-1];

    always_comb begin
        n_flag = r_msb;
        z_flag = (bus.ALUResult == '0);
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (bus.ALUControl)
            OP_ADD: begin
                // A + B carries out exactly when A exceeds the complement of B
                c_flag = (bus.SrcA > ~bus.SrcB);
                v_flag = (a_msb == b_msb) & (r_msb != a_msb);
            end
            OP_SUB: begin
                c_flag = (bus.SrcA >= bus.SrcB);
                v_flag = (a_msb != b_msb) & (r_msb != a_msb);
            end
            default: begin
                c_flag = 1'b0;
                v_flag = 1'b0;
            end
        endcase
        new_flags = {v_flag, c_flag, z_flag, n_flag};
    end

    always_comb begin
        state_d  = state_q;
        flags_d  = flags_q;
        shadow_d = shadow_q;
        case (state_q)
            CLEAN: begin
                if (we) begin
                    shadow_d = flags_q;
                    flags_d  = new_flags;
                    state_d  = PENDING;
                end
            end
            PENDING: begin
                if (bus.Flush) begin
                    flags_d = shadow_q;
                    state_d = CLEAN;
                end else if (bus.Commit && we) begin
                    shadow_d = flags_q;
                    flags_d  = new_flags;
                end else if (bus.Commit) begin
                    state_d = CLEAN;
                end else if (we) begin
                    flags_d = new_flags;
                end
            end
            default: state_d = CLEAN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= CLEAN;
            flags_q  <= 4'b0000;
            shadow_q <= 4'b0000;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            shadow_q <= shadow_d;
        end
    end

`ifdef FLAGS_BYPASS_EN
    assign bus.Flags = (we && !bus.Flush) ? new_flags : flags_q;
`else
    assign bus.Flags = flags_q;
`endif
    assign bus.FlagsPending = (state_q == PENDING);

endmodule
